// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - dual-write, dual-read register file with busy scoreboard
// Reads are write-first and registered; register 0 is hardwired to zero.
module reg_file_mp #(
  parameter int XLEN      = 64,
  parameter int NREG      = 32,
  parameter int INIT_MODE = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rd_en,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            wr0_en,
  input  logic [AW-1:0]   wr0_addr,
  input  logic [XLEN-1:0] wr0_data,
  input  logic            wr1_en,
  input  logic [AW-1:0]   wr1_addr,
  input  logic [XLEN-1:0] wr1_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_addr,
  output logic [NREG-1:0] busy_vec
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;

  logic            wr0_hit;
  logic            wr1_hit;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] busy_after_wr;
  logic [NREG-1:0] busy_next;
  logic [XLEN-1:0] rs1_next;
  logic [XLEN-1:0] rs2_next;
  logic            rs1_busy_next;
  logic            rs2_busy_next;

  always_comb begin
    wr0_hit  = wr0_en && (wr0_addr != '0);
    wr1_hit  = wr1_en && (wr1_addr != '0);
    clr_mask = '0;
    set_mask = '0;
    if (wr0_hit) clr_mask[wr0_addr] = 1'b1;
    if (wr1_hit) clr_mask[wr1_addr] = 1'b1;
    if (issue_en && (issue_addr != '0)) set_mask[issue_addr] = 1'b1;
    // Read ports see write clears but not same-cycle issue sets.
    busy_after_wr = busy & ~clr_mask;
    busy_next     = busy_after_wr | set_mask;

    rs1_next = regs[rs1_addr];
    if (wr0_hit && (wr0_addr == rs1_addr)) rs1_next = wr0_data;
    if (wr1_hit && (wr1_addr == rs1_addr)) rs1_next = wr1_data;
    if (rs1_addr == '0) rs1_next = '0;
    rs1_busy_next = busy_after_wr[rs1_addr];

    rs2_next = regs[rs2_addr];
    if (wr0_hit && (wr0_addr == rs2_addr)) rs2_next = wr0_data;
    if (wr1_hit && (wr1_addr == rs2_addr)) rs2_next = wr1_data;
    if (rs2_addr == '0) rs2_next = '0;
    rs2_busy_next = busy_after_wr[rs2_addr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (INIT_MODE != 0) ? XLEN'(i) : '0;
      end
      busy     <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      rs1_busy <= 1'b0;
      rs2_busy <= 1'b0;
    end else begin
      // wr1 is applied last so it wins a same-address collision.
      if (wr0_hit) regs[wr0_addr] <= wr0_data;
      if (wr1_hit) regs[wr1_addr] <= wr1_data;
      busy <= busy_next;
      if (rd_en) begin
        rs1_data <= rs1_next;
        rs2_data <= rs2_next;
        rs1_busy <= rs1_busy_next;
        rs2_busy <= rs2_busy_next;
      end
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - randomized and directed bench for reg_file_mp
// Reference model applies writes, then reads, then issues, each cycle.
module tb_reg_file_mp;

  logic        clock;
  logic        reset;
  logic        rd_en;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [63:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        wr0_en, wr1_en;
  logic [4:0]  wr0_addr, wr1_addr;
  logic [63:0] wr0_data, wr1_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_reg [32];
  logic [31:0] m_busy;
  logic [63:0] exp_rs1_data, exp_rs2_data;
  logic        exp_rs1_busy, exp_rs2_busy;

  reg_file_mp dut (
    .clock(clock), .reset(reset), .rd_en(rd_en),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(busy_vec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr_in();
    reset = 0; rd_en = 0; rs1_addr = 0; rs2_addr = 0;
    wr0_en = 0; wr0_addr = 0; wr0_data = 0;
    wr1_en = 0; wr1_addr = 0; wr1_data = 0;
    issue_en = 0; issue_addr = 0;
  endtask

  // Advance one edge and update the reference model from the held inputs.
  task automatic tick();
    @(posedge clock);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 64'(i);
      m_busy = 0;
      exp_rs1_data = 0; exp_rs2_data = 0;
      exp_rs1_busy = 0; exp_rs2_busy = 0;
    end else begin
      if (wr0_en && wr0_addr != 0) begin m_reg[wr0_addr] = wr0_data; m_busy[wr0_addr] = 0; end
      if (wr1_en && wr1_addr != 0) begin m_reg[wr1_addr] = wr1_data; m_busy[wr1_addr] = 0; end
      if (rd_en) begin
        exp_rs1_data = (rs1_addr == 0) ? 64'd0 : m_reg[rs1_addr];
        exp_rs2_data = (rs2_addr == 0) ? 64'd0 : m_reg[rs2_addr];
        exp_rs1_busy = m_busy[rs1_addr];
        exp_rs2_busy = m_busy[rs2_addr];
      end
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1;
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1; rd_en = 1; rs1_addr = 5; rs2_addr = 9;
    wr0_en = 1; wr0_addr = 5; wr0_data = {$urandom, $urandom};
    issue_en = 1; issue_addr = 9;
    tick();
    total++; if (rs1_data !== 64'd0) begin bad++; $display("FAIL reset_rs1_data got=%h exp=0", rs1_data); end
    total++; if (rs2_data !== 64'd0) begin bad++; $display("FAIL reset_rs2_data got=%h exp=0", rs2_data); end
    total++; if ({rs1_busy, rs2_busy} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b%b exp=00", rs1_busy, rs2_busy); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL reset_busy_vec got=%h exp=0", busy_vec); end
    clr_in();
    rd_en = 1; rs1_addr = 7; rs2_addr = 31;
    tick();
    total++; if (rs1_data !== 64'd7) begin bad++; $display("FAIL init_rs1 got=%h exp=7", rs1_data); end
    total++; if (rs2_data !== 64'd31) begin bad++; $display("FAIL init_rs2 got=%h exp=1f", rs2_data); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL init_busy_vec got=%h exp=0", busy_vec); end
    rs1_addr = 5;
    tick();
    total++; if (rs1_data !== 64'd5) begin bad++; $display("FAIL init_reg5 got=%h exp=5", rs1_data); end
  endtask

  task automatic test_bypass();
    clr_in();
    wr0_en = 1; wr0_addr = 3; wr0_data = 64'hDEAD_BEEF_0000_0001;
    wr1_en = 1; wr1_addr = 10; wr1_data = 64'h1234_5678_9ABC_DEF0;
    rd_en = 1; rs1_addr = 3; rs2_addr = 10;
    tick();
    total++; if (rs1_data !== 64'hDEADBEEF00000001) begin bad++; $display("FAIL bypass_wr0 got=%h exp=deadbeef00000001", rs1_data); end
    total++; if (rs2_data !== 64'h123456789ABCDEF0) begin bad++; $display("FAIL bypass_wr1 got=%h exp=123456789abcdef0", rs2_data); end
    clr_in();
    wr0_en = 1; wr0_addr = 11; wr0_data = 64'hAAAA;
    wr1_en = 1; wr1_addr = 11; wr1_data = 64'hBBBB;
    rd_en = 1; rs1_addr = 11;
    tick();
    total++; if (rs1_data !== 64'hBBBB) begin bad++; $display("FAIL bypass_wr1_priority got=%h exp=bbbb", rs1_data); end
  endtask

  task automatic test_wr_priority();
    clr_in();
    wr0_en = 1; wr0_addr = 9; wr0_data = 64'h11;
    wr1_en = 1; wr1_addr = 9; wr1_data = 64'h22;
    tick();
    clr_in();
    rd_en = 1; rs1_addr = 9;
    tick();
    total++; if (rs1_data !== 64'h22) begin bad++; $display("FAIL wr1_wins got=%h exp=22", rs1_data); end
    clr_in();
    wr0_en = 1; wr0_addr = 0; wr0_data = 64'hFF;
    issue_en = 1; issue_addr = 0;
    rd_en = 1; rs1_addr = 0; rs2_addr = 0;
    tick();
    total++; if (rs1_data !== 64'd0) begin bad++; $display("FAIL reg0_read got=%h exp=0", rs1_data); end
    total++; if (busy_vec[0] !== 1'b0) begin bad++; $display("FAIL reg0_busy got=%b exp=0", busy_vec[0]); end
  endtask

  task automatic test_scoreboard();
    clr_in();
    issue_en = 1; issue_addr = 4;
    tick();
    clr_in();
    total++; if (busy_vec[4] !== 1'b1) begin bad++; $display("FAIL issue_sets got=%b exp=1", busy_vec[4]); end
    rd_en = 1; rs2_addr = 4;
    issue_en = 1; issue_addr = 4;
    tick();
    total++; if (rs2_busy !== 1'b1) begin bad++; $display("FAIL rs2_busy_set got=%b exp=1", rs2_busy); end
    total++; if (busy_vec[4] !== 1'b1) begin bad++; $display("FAIL reissue_busy got=%b exp=1", busy_vec[4]); end
    clr_in();
    wr1_en = 1; wr1_addr = 4; wr1_data = 64'h5;
    rd_en = 1; rs2_addr = 4;
    tick();
    total++; if (rs2_data !== 64'h5) begin bad++; $display("FAIL clear_rs2_data got=%h exp=5", rs2_data); end
    total++; if (rs2_busy !== 1'b0) begin bad++; $display("FAIL clear_rs2_busy got=%b exp=0", rs2_busy); end
    total++; if (busy_vec[4] !== 1'b0) begin bad++; $display("FAIL clear_busy_vec got=%b exp=0", busy_vec[4]); end
    clr_in();
    issue_en = 1; issue_addr = 8; rd_en = 1; rs1_addr = 8;
    tick();
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL issue_not_visible got=%b exp=0", rs1_busy); end
    total++; if (busy_vec[8] !== 1'b1) begin bad++; $display("FAIL issue8_busy got=%b exp=1", busy_vec[8]); end
  endtask

  task automatic test_issue_write_same();
    clr_in();
    issue_en = 1; issue_addr = 6;
    wr0_en = 1; wr0_addr = 6; wr0_data = 64'h1;
    rd_en = 1; rs1_addr = 6; rs2_addr = 6;
    tick();
    total++; if (busy_vec[6] !== 1'b1) begin bad++; $display("FAIL new_producer_busy got=%b exp=1", busy_vec[6]); end
    total++; if (rs1_data !== 64'h1) begin bad++; $display("FAIL reg6_data got=%h exp=1", rs1_data); end
    total++; if (rs1_busy !== 1'b0) begin bad++; $display("FAIL reg6_rs1_busy got=%b exp=0", rs1_busy); end
    for (int c = 0; c < 3; c++) begin
      clr_in();
      rs1_addr = 5'($urandom_range(1, 31)); rs2_addr = 6;
      wr0_en = 1; wr0_addr = 6; wr0_data = {$urandom, $urandom};
      tick();
      total++; if (rs1_data !== 64'h1 || rs2_data !== 64'h1) begin bad++; $display("FAIL hold_data c=%0d got=%h/%h exp=1", c, rs1_data, rs2_data); end
      total++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin bad++; $display("FAIL hold_busy c=%0d got=%b%b exp=00", c, rs1_busy, rs2_busy); end
    end
  endtask

  task automatic test_reset_dominates();
    clr_in();
    reset = 1;
    wr0_en = 1; wr0_addr = 2; wr0_data = 64'hAB;
    issue_en = 1; issue_addr = 2;
    tick();
    clr_in();
    rd_en = 1; rs1_addr = 2;
    tick();
    total++; if (rs1_data !== 64'd2) begin bad++; $display("FAIL reset_drops_write got=%h exp=2", rs1_data); end
    total++; if (busy_vec !== 32'd0) begin bad++; $display("FAIL reset_drops_issue got=%h exp=0", busy_vec); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      clr_in();
      reset      = ($urandom_range(0, 59) == 0);
      rd_en      = $urandom_range(0, 3) != 0;
      rs1_addr   = 5'($urandom_range(0, 15));
      rs2_addr   = 5'($urandom_range(0, 15));
      wr0_en     = $urandom_range(0, 1);
      wr0_addr   = 5'($urandom_range(0, 15));
      wr0_data   = {$urandom, $urandom};
      wr1_en     = $urandom_range(0, 1);
      wr1_addr   = 5'($urandom_range(0, 15));
      wr1_data   = {$urandom, $urandom};
      issue_en   = $urandom_range(0, 1);
      issue_addr = 5'($urandom_range(0, 15));
      tick();
      total++; if (rs1_data !== exp_rs1_data) begin bad++; $display("FAIL rand_rs1_data n=%0d got=%h exp=%h", n, rs1_data, exp_rs1_data); end
      total++; if (rs2_data !== exp_rs2_data) begin bad++; $display("FAIL rand_rs2_data n=%0d got=%h exp=%h", n, rs2_data, exp_rs2_data); end
      total++; if (rs1_busy !== exp_rs1_busy) begin bad++; $display("FAIL rand_rs1_busy n=%0d got=%b exp=%b", n, rs1_busy, exp_rs1_busy); end
      total++; if (rs2_busy !== exp_rs2_busy) begin bad++; $display("FAIL rand_rs2_busy n=%0d got=%b exp=%b", n, rs2_busy, exp_rs2_busy); end
      total++; if (busy_vec !== m_busy) begin bad++; $display("FAIL rand_busy_vec n=%0d got=%h exp=%h", n, busy_vec, m_busy); end
    end
  endtask

  initial begin
    clr_in();
    reset = 1;
    tick();
    test_reset();
    test_bypass();
    test_wr_priority();
    test_scoreboard();
    test_issue_write_same();
    test_reset_dominates();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
